rw_ctrl_logic: RTL and testbench
================================

RW_CTRL_LOGIC -- requirements
Module: rw_ctrl_logic

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset; all state changes on clk rising edge.
REQ-002 clk  input  1  system clock.
REQ-003 reset  input  1  synchronous active-high reset.
REQ-004 cs_n, rd_n, wr_n  input  1 each  active-low bus chip-select, read and write strobes, sampled on clk.
REQ-005 addr  input  2  A1:A0; 00/01/10 select counters 0/1/2, 11 selects the control-word register.
REQ-006 dataBus  input  8  write data from the host.
REQ-007 contWord0/1/2  output  6 each  {RW1,RW0,M2,M1,M0,BCD} sent to each countInt.
REQ-008 dataIn  output  8  captured write byte, shared by all counters.
REQ-009 DE0/1/2  output  1 each  one-cycle count-byte write enable per counter.
REQ-010 countIn0/1/2  input  16 each  live current count from each counter.
REQ-011 outIn0/1/2  input  1 each  counter OUT pin, used for status bytes.
REQ-012 rdData  output  8  read byte; rdValid  output  1  high while rdData is valid.

Function
REQ-013 SHALL capture addr and dataBus every cycle with cs_n=0, wr_n=0 and rd_n=1; a write event is the first cycle that samples wr_n=1 after a capture.
REQ-014 SHALL treat cycles with rd_n=0 and wr_n=0 together as no access: no capture, no event, no pointer change.
REQ-015 A write event to addr 00-10 SHALL drive dataIn with the captured byte and pulse the matching DE for exactly one cycle, on the cycle after the event.
REQ-016 A control write with SC=00-10 and RW!=00 SHALL load contWordN with captured bits [5:0] on the cycle after the event, reset that counter's read and write byte pointers to LSB, and set its null-count flag.
REQ-017 A control write with SC=00-10 and RW=00 (latch command) SHALL copy countInN into latchN, unless latchN already holds an unread value; contWordN is unchanged.
REQ-018 Per-counter write pointer: RW=01 every byte is LSB; RW=10 every byte is MSB; RW=11 alternates LSB, MSB. The null-count flag clears when the last byte of the sequence is written.
REQ-019 While cs_n=0 and rd_n=0, rdValid SHALL be 1 and rdData SHALL hold the selected byte, updated one cycle after sampling: latched value if present, otherwise live countInN; the byte is chosen by the read pointer using the same RW rules as REQ-018.
REQ-020 A read event (first rd_n=1 after a read) SHALL advance the read pointer; the latch releases after its final byte (one byte for RW=01/10, two for RW=11).
REQ-021 A read of addr 11 SHALL return 8'h00 and change no state.
REQ-022 rdValid SHALL be 0 and rdData 8'h00 when not reading.

Reset
REQ-023 On reset, SHALL set contWord0/1/2=6'b110000, dataIn=8'h00, DE*=0, rdData=8'h00, rdValid=0, clear all latches, pointers (LSB) and null-count flags, and discard any access in progress.

Configuration
REQ-024 Macro READBACK_EN: when defined, a control write with SC=11 is read-back: D5=0 latches the count and D4=0 latches status {outInN, nullCountN, contWordN} for every counter whose D3/D2/D1 bit (CNT2/1/0) is set. The first read returns latched status and subsequent reads return the latched count. A repeat latch of an unread item is ignored.
REQ-025 Without READBACK_EN, SC=11 control writes SHALL be ignored and no status logic is compiled.

Structure
REQ-026 Shared package pit_pkg SHALL hold the addr codes, RW encodings (LATCH/LSB/MSB/LSB_MSB), SC codes and the contWord reset constant.
REQ-027 Per-counter latch, read and write pointers and null-count tracking SHALL live in sub-module rd_latch_ctrl, instantiated three times.

Verification
REQ-028 Control write 8'b00_11_010_0 to addr 11 -> contWord0=6'b110100 one cycle after wr_n rises; other counters unchanged.
REQ-029 Writes 8'h0F then 8'h17 to addr 00 (RW=11) -> dataIn=8'h0F with a DE0 pulse, then 8'h17 with a DE0 pulse; each pulse lasts one cycle; null-count is cleared after the second write.
REQ-030 Latch command 8'b01_00_0000 with countIn1=16'h1234, then countIn1 changes -> two reads of addr 01 return 8'h34 then 8'h12; a third read returns the live LSB.
REQ-031 RW=01 on counter 2 with countIn2=16'hABCD -> repeated reads return 8'hCD.
REQ-032 READBACK_EN: 8'b11_00_0010 with outIn0=1 and contWord0=6'b110100 -> reads return 8'hB4, then the count LSB, then the MSB; without the macro there is no state change.
REQ-033 rd_n and wr_n low together, then reset asserted mid-read -> no DE pulse, and all outputs hold their REQ-023 values on the cycle after reset.

Source files
------------

// File: rtl/pit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pit_pkg
// Purpose  : Shared encodings for the timer read/write control block.
// Revision : 1.0 - initial release
// ============================================================================
package pit_pkg;

    typedef enum logic [1:0] {
        ADDR_CNT0 = 2'b00,
        ADDR_CNT1 = 2'b01,
        ADDR_CNT2 = 2'b10,
        ADDR_CTRL = 2'b11
    } addr_e;

    typedef enum logic [1:0] {
        RW_LATCH   = 2'b00,
        RW_LSB     = 2'b01,
        RW_MSB     = 2'b10,
        RW_LSB_MSB = 2'b11
    } rw_e;

    typedef enum logic [1:0] {
        SC_CNT0     = 2'b00,
        SC_CNT1     = 2'b01,
        SC_CNT2     = 2'b10,
        SC_READBACK = 2'b11
    } sc_e;

    localparam logic [5:0] C_CW_RESET = 6'b110000;
    localparam int         C_NUM_CNT  = 3;

    // Byte of a 16-bit value addressed by access mode and byte pointer.
    function automatic logic [7:0] sel_byte(input logic [1:0] rw, input logic ptr,
                                            input logic [15:0] val);
        case (rw)
            RW_LSB:  return val[7:0];
            RW_MSB:  return val[15:8];
            default: return ptr ? val[15:8] : val[7:0];
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/rd_latch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : rd_latch_ctrl
// Purpose  : Per-counter control word, count latch, byte pointers and
//            null-count tracking. Status latch present with READBACK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module rd_latch_ctrl
    import pit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        cw_load,
    input  logic [5:0]  cw_data,
    input  logic        latch_cmd,
    input  logic        wr_byte,
    input  logic        rd_evt,
    input  logic [15:0] count_in,
`ifdef READBACK_EN
    input  logic        status_cmd,
    input  logic        out_in,
`endif
    output logic [5:0]  cw,
    output logic [7:0]  rd_byte
);

    logic [5:0]  r_cw;
    logic        r_wr_ptr;
    logic        r_rd_ptr;
    logic        r_null;
    logic [15:0] r_latch;
    logic        r_latch_vld;
    logic        w_status_vld;
    logic        w_two_byte;
    logic        w_rd_count;

    assign w_two_byte = (r_cw[5:4] == RW_LSB_MSB);
    // A pending status byte absorbs the next read without moving the pointer.
    assign w_rd_count = rd_evt && !w_status_vld;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cw        <= C_CW_RESET;
            r_wr_ptr    <= 1'b0;
            r_rd_ptr    <= 1'b0;
            r_null      <= 1'b0;
            r_latch     <= 16'h0000;
            r_latch_vld <= 1'b0;
        end else begin
            if (wr_byte) begin
                if (w_two_byte) begin
                    r_wr_ptr <= ~r_wr_ptr;
                    if (r_wr_ptr) r_null <= 1'b0;
                end else begin
                    r_null <= 1'b0;
                end
            end
            if (w_rd_count) begin
                if (w_two_byte) r_rd_ptr <= ~r_rd_ptr;
                if (r_latch_vld && (!w_two_byte || r_rd_ptr)) r_latch_vld <= 1'b0;
            end
            if (latch_cmd && !r_latch_vld) begin
                r_latch     <= count_in;
                r_latch_vld <= 1'b1;
            end
            if (cw_load) begin
                r_cw     <= cw_data;
                r_wr_ptr <= 1'b0;
                r_rd_ptr <= 1'b0;
                r_null   <= 1'b1;
            end
        end
    end

`ifdef READBACK_EN
    logic [7:0] r_status;
    logic       r_status_vld;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_status     <= 8'h00;
            r_status_vld <= 1'b0;
        end else if (rd_evt && r_status_vld) begin
            r_status_vld <= 1'b0;
        end else if (status_cmd && !r_status_vld) begin
            r_status     <= {out_in, r_null, r_cw};
            r_status_vld <= 1'b1;
        end
    end

    assign w_status_vld = r_status_vld;
`else
    assign w_status_vld = 1'b0;
`endif

    always_comb begin
        rd_byte = sel_byte(r_cw[5:4], r_rd_ptr, r_latch_vld ? r_latch : count_in);
`ifdef READBACK_EN
        if (r_status_vld) rd_byte = r_status;
`endif
    end

    assign cw = r_cw;

endmodule
`default_nettype wire

// File: rtl/rw_ctrl_logic.sv
`default_nettype none
// ============================================================================
// Module   : rw_ctrl_logic
// Purpose  : Host bus read/write decoder for a three-counter interval timer.
//            Define READBACK_EN to enable the read-back command.
// Revision : 1.0 - initial release
// ============================================================================
module rw_ctrl_logic
    import pit_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        cs_n,
    input  logic        rd_n,
    input  logic        wr_n,
    input  logic [1:0]  addr,
    input  logic [7:0]  dataBus,
    output logic [5:0]  contWord0,
    output logic [5:0]  contWord1,
    output logic [5:0]  contWord2,
    output logic [7:0]  dataIn,
    output logic        DE0,
    output logic        DE1,
    output logic        DE2,
    input  logic [15:0] countIn0,
    input  logic [15:0] countIn1,
    input  logic [15:0] countIn2,
    input  logic        outIn0,
    input  logic        outIn1,
    input  logic        outIn2,
    output logic [7:0]  rdData,
    output logic        rdValid
);

    logic        r_wr_pend;
    logic [1:0]  r_wr_addr;
    logic [7:0]  r_wr_data;
    logic        r_rd_pend;
    logic [1:0]  r_rd_addr;
    logic [7:0]  r_data_in;
    logic [2:0]  r_de;
    logic [7:0]  r_rd_data;
    logic        r_rd_valid;

    logic        w_wr_cap;
    logic        w_rd_act;
    logic        w_wr_done;
    logic        w_rd_done;
    logic [1:0]  w_sc;
    logic [2:0]  w_cw_load;
    logic [2:0]  w_latch_cmd;
    logic [2:0]  w_wr_byte;
    logic [2:0]  w_rd_evt;
    logic [7:0]  w_rd_sel;
    logic [15:0] w_count   [C_NUM_CNT];
    logic [5:0]  w_cw      [C_NUM_CNT];
    logic [7:0]  w_rd_byte [C_NUM_CNT];
`ifdef READBACK_EN
    logic [2:0]  w_status_cmd;
    logic [2:0]  w_out;
    assign w_out = {outIn2, outIn1, outIn0};
`else
    logic        w_unused_out;
    assign w_unused_out = ^{outIn2, outIn1, outIn0};
`endif

    // Both strobes low at once is treated as no access at all.
    assign w_wr_cap  = !cs_n && !wr_n && rd_n;
    assign w_rd_act  = !cs_n && !rd_n && wr_n;
    assign w_wr_done = r_wr_pend && wr_n;
    assign w_rd_done = r_rd_pend && rd_n;
    assign w_sc      = r_wr_data[7:6];

    assign w_count[0] = countIn0;
    assign w_count[1] = countIn1;
    assign w_count[2] = countIn2;

    always_comb begin
        w_cw_load   = 3'b000;
        w_latch_cmd = 3'b000;
        w_wr_byte   = 3'b000;
        w_rd_evt    = 3'b000;
`ifdef READBACK_EN
        w_status_cmd = 3'b000;
`endif
        if (w_wr_done) begin
            if (r_wr_addr != ADDR_CTRL) begin
                w_wr_byte[r_wr_addr] = 1'b1;
            end else if (w_sc != SC_READBACK) begin
                if (r_wr_data[5:4] == RW_LATCH) w_latch_cmd[w_sc] = 1'b1;
                else                            w_cw_load[w_sc]   = 1'b1;
            end
`ifdef READBACK_EN
            else begin
                for (int i = 0; i < C_NUM_CNT; i++) begin
                    if (r_wr_data[i+1]) begin
                        w_latch_cmd[i]  = !r_wr_data[5];
                        w_status_cmd[i] = !r_wr_data[4];
                    end
                end
            end
`endif
        end
        if (w_rd_done && r_rd_addr != ADDR_CTRL) w_rd_evt[r_rd_addr] = 1'b1;
    end

    always_comb begin
        w_rd_sel = 8'h00;
        case (addr)
            ADDR_CNT0: w_rd_sel = w_rd_byte[0];
            ADDR_CNT1: w_rd_sel = w_rd_byte[1];
            ADDR_CNT2: w_rd_sel = w_rd_byte[2];
            default:   w_rd_sel = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_pend  <= 1'b0;
            r_wr_addr  <= 2'b00;
            r_wr_data  <= 8'h00;
            r_rd_pend  <= 1'b0;
            r_rd_addr  <= 2'b00;
            r_data_in  <= 8'h00;
            r_de       <= 3'b000;
            r_rd_data  <= 8'h00;
            r_rd_valid <= 1'b0;
        end else begin
            if (w_wr_cap) begin
                r_wr_pend <= 1'b1;
                r_wr_addr <= addr;
                r_wr_data <= dataBus;
            end else if (w_wr_done) begin
                r_wr_pend <= 1'b0;
            end
            if (w_rd_act) begin
                r_rd_pend <= 1'b1;
                r_rd_addr <= addr;
            end else if (w_rd_done) begin
                r_rd_pend <= 1'b0;
            end
            r_de <= w_wr_byte;
            if (|w_wr_byte) r_data_in <= r_wr_data;
            r_rd_valid <= w_rd_act;
            r_rd_data  <= w_rd_act ? w_rd_sel : 8'h00;
        end
    end

    for (genvar i = 0; i < C_NUM_CNT; i++) begin : g_cnt
        rd_latch_ctrl u_ctrl (
            .clk        (clk),
            .rst        (reset),
            .cw_load    (w_cw_load[i]),
            .cw_data    (r_wr_data[5:0]),
            .latch_cmd  (w_latch_cmd[i]),
            .wr_byte    (w_wr_byte[i]),
            .rd_evt     (w_rd_evt[i]),
            .count_in   (w_count[i]),
`ifdef READBACK_EN
            .status_cmd (w_status_cmd[i]),
            .out_in     (w_out[i]),
`endif
            .cw         (w_cw[i]),
            .rd_byte    (w_rd_byte[i])
        );
    end

    assign contWord0 = w_cw[0];
    assign contWord1 = w_cw[1];
    assign contWord2 = w_cw[2];
    assign dataIn    = r_data_in;
    assign DE0       = r_de[0];
    assign DE1       = r_de[1];
    assign DE2       = r_de[2];
    assign rdData    = r_rd_data;
    assign rdValid   = r_rd_valid;

endmodule
`default_nettype wire

// File: tb/tb_rw_ctrl_logic.sv
`default_nettype none
// ============================================================================
// Module   : tb_rw_ctrl_logic
// Purpose  : Self-checking bench for rw_ctrl_logic (READBACK_EN aware).
// Revision : 1.0 - initial release
// ============================================================================
module tb_rw_ctrl_logic;

    logic        clk = 1'b0;
    logic        reset, cs_n, rd_n, wr_n;
    logic [1:0]  addr;
    logic [7:0]  dataBus;
    logic [5:0]  contWord0, contWord1, contWord2;
    logic [7:0]  dataIn;
    logic        DE0, DE1, DE2;
    logic [15:0] countIn0, countIn1, countIn2;
    logic        outIn0, outIn1, outIn2;
    logic [7:0]  rdData;
    logic        rdValid;

    rw_ctrl_logic dut (
        .clk(clk), .reset(reset), .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n),
        .addr(addr), .dataBus(dataBus),
        .contWord0(contWord0), .contWord1(contWord1), .contWord2(contWord2),
        .dataIn(dataIn), .DE0(DE0), .DE1(DE1), .DE2(DE2),
        .countIn0(countIn0), .countIn1(countIn1), .countIn2(countIn2),
        .outIn0(outIn0), .outIn1(outIn1), .outIn2(outIn2),
        .rdData(rdData), .rdValid(rdValid)
    );

    always #5 clk = ~clk;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] rd_q [$];
    logic [9:0] wr_q [$];
    logic [2:0] prev_de = 3'b000;

    localparam logic [1:0] OP_WR = 2'd0;
    localparam logic [1:0] OP_RD = 2'd1;
    localparam logic [1:0] OP_CW = 2'd2;

    typedef struct {
        logic [1:0] op;
        logic [1:0] a;
        logic [7:0] d;
    } vec_t;

    vec_t vecs [$];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        if (a != 2'd3) wr_q.push_back({a, d});
        cs_n = 1'b0; wr_n = 1'b0; rd_n = 1'b1; addr = a; dataBus = d;
        tick();
        wr_n = 1'b1; cs_n = 1'b1;
        tick();
    endtask

    task automatic rd(input logic [1:0] a, input logic [7:0] exp);
        rd_q.push_back(exp);
        cs_n = 1'b0; rd_n = 1'b0; wr_n = 1'b1; addr = a;
        tick();
        rd_n = 1'b1; cs_n = 1'b1;
        tick();
    endtask

    function automatic logic [5:0] cw_of(input logic [1:0] n);
        case (n)
            2'd0:    return contWord0;
            2'd1:    return contWord1;
            default: return contWord2;
        endcase
    endfunction

    task automatic check_reset_state(input string tag);
        check({tag, "_cw0"}, 16'(contWord0), 16'h30);
        check({tag, "_cw1"}, 16'(contWord1), 16'h30);
        check({tag, "_cw2"}, 16'(contWord2), 16'h30);
        check({tag, "_datain"}, 16'(dataIn), 16'h00);
        check({tag, "_de"}, 16'({DE2, DE1, DE0}), 16'h0);
        check({tag, "_rddata"}, 16'(rdData), 16'h00);
        check({tag, "_rdvalid"}, 16'(rdValid), 16'h0);
    endtask

    function automatic void add(input logic [1:0] op, input logic [1:0] a, input logic [7:0] d);
        vec_t v;
        v.op = op; v.a = a; v.d = d;
        vecs.push_back(v);
    endfunction

    // Output-side scoreboard: every read byte and every DE pulse must match the queue head.
    always @(posedge clk) begin
        logic [2:0] de;
        logic [9:0] e;
        #1;
        if (rdValid) begin
            if (rd_q.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL rd_unexpected: got rdData %h with nothing expected", rdData);
            end else begin
                check("rd_data", 16'(rdData), 16'(rd_q.pop_front()));
            end
        end else begin
            check("rd_idle", 16'(rdData), 16'h00);
        end
        de = {DE2, DE1, DE0};
        for (int i = 0; i < 3; i++) begin
            if (de[i]) begin
                check("de_width", 16'(prev_de[i]), 16'h0);
                if (wr_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL de_unexpected: got DE%0d=1 expected none", i);
                end else begin
                    e = wr_q.pop_front();
                    check("de_sel", 16'(i), 16'(e[9:8]));
                    check("data_in", 16'(dataIn), 16'(e[7:0]));
                end
            end
        end
        prev_de = de;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; cs_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; addr = 2'd0; dataBus = 8'h00;
        countIn0 = 16'h5678; countIn1 = 16'h1234; countIn2 = 16'hABCD;
        outIn0 = 1'b0; outIn1 = 1'b0; outIn2 = 1'b0;
        tick(); tick();
        check_reset_state("reset");
        reset = 1'b0;
        tick();

        add(OP_WR, 2'd3, 8'h34); add(OP_CW, 2'd0, 8'h34); add(OP_CW, 2'd1, 8'h30); add(OP_CW, 2'd2, 8'h30);
        add(OP_WR, 2'd0, 8'h0F); add(OP_WR, 2'd0, 8'h17);
        add(OP_RD, 2'd1, 8'h34); add(OP_RD, 2'd1, 8'h12);
        add(OP_WR, 2'd3, 8'h90); add(OP_CW, 2'd2, 8'h10);
        add(OP_RD, 2'd2, 8'hCD); add(OP_RD, 2'd2, 8'hCD); add(OP_RD, 2'd2, 8'hCD);
        add(OP_WR, 2'd3, 8'h60); add(OP_CW, 2'd1, 8'h20);
        add(OP_RD, 2'd1, 8'h12); add(OP_RD, 2'd1, 8'h12);
        add(OP_WR, 2'd3, 8'h70); add(OP_CW, 2'd1, 8'h30);
        add(OP_RD, 2'd3, 8'h00);
        add(OP_WR, 2'd1, 8'hAA); add(OP_WR, 2'd2, 8'h55);
        add(OP_WR, 2'd3, 8'h40); add(OP_CW, 2'd1, 8'h30);

        for (int i = 0; i < vecs.size(); i++) begin
            case (vecs[i].op)
                OP_WR:   wr(vecs[i].a, vecs[i].d);
                OP_RD:   rd(vecs[i].a, vecs[i].d);
                default: check($sformatf("cw%0d_vec%0d", vecs[i].a, i),
                               16'(cw_of(vecs[i].a)), 16'(vecs[i].d[5:0]));
            endcase
        end

        // Latched count survives live changes, then the live count returns.
        countIn1 = 16'hBEEF;
        rd(2'd1, 8'h34); rd(2'd1, 8'h12); rd(2'd1, 8'hEF); rd(2'd1, 8'hBE);

        // A second latch while the first is unread is ignored.
        countIn1 = 16'h1234; wr(2'd3, 8'h40);
        countIn1 = 16'h5555; wr(2'd3, 8'h40);
        countIn1 = 16'h9999;
        rd(2'd1, 8'h34); rd(2'd1, 8'h12); rd(2'd1, 8'h99); rd(2'd1, 8'h99);

        // Both strobes low together: no capture, no DE.
        cs_n = 1'b0; rd_n = 1'b0; wr_n = 1'b0; addr = 2'd0; dataBus = 8'hEE;
        tick();
        rd_n = 1'b1; wr_n = 1'b1; cs_n = 1'b1;
        tick(); tick();
        check("no_capture_datain", 16'(dataIn), 16'h55);
        check("no_capture_de0", 16'(DE0), 16'h0);

        // Reset in the middle of a read.
        rd_q.push_back(8'h78);
        cs_n = 1'b0; rd_n = 1'b0; addr = 2'd0;
        tick();
        reset = 1'b1;
        tick();
        check_reset_state("midrd");
        reset = 1'b0; rd_n = 1'b1; cs_n = 1'b1;
        tick();

        // Reset with a write captured but not yet completed.
        cs_n = 1'b0; wr_n = 1'b0; addr = 2'd0; dataBus = 8'h77;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0; wr_n = 1'b1; cs_n = 1'b1;
        tick(); tick();
        check("discard_wr_de0", 16'(DE0), 16'h0);
        check("discard_wr_datain", 16'(dataIn), 16'h00);

`ifdef READBACK_EN
        wr(2'd3, 8'h34);
        wr(2'd0, 8'h0F);
        outIn0 = 1'b1;
        wr(2'd3, 8'hE2);
        rd(2'd0, 8'hF4); rd(2'd0, 8'h78); rd(2'd0, 8'h56);
        wr(2'd0, 8'h17);
        wr(2'd3, 8'hC2);
        countIn0 = 16'h1111;
        rd(2'd0, 8'hB4); rd(2'd0, 8'h78); rd(2'd0, 8'h56); rd(2'd0, 8'h11);
`else
        wr(2'd3, 8'hC2);
        check("rb_off_cw0", 16'(contWord0), 16'h30);
        check("rb_off_cw1", 16'(contWord1), 16'h30);
        check("rb_off_cw2", 16'(contWord2), 16'h30);
        rd(2'd0, 8'h78); rd(2'd0, 8'h56);
`endif

        tick(); tick();
        check("rd_q_drained", 16'(rd_q.size()), 16'h0);
        check("wr_q_drained", 16'(wr_q.size()), 16'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
